// File: rtl/iotdf_param.sv
// Parametrised IoT data filter: assembles IN_W-bit beats into DATA_W-bit samples and applies one of eight group filters.
// Define IOTDF_SIGNED_EN to treat samples and thresholds as two's-complement (signed compares, arithmetic-shift average).
module iotdf_param #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8,
    parameter int GRP    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic [2:0]        fn_sel,
    input  logic [DATA_W-1:0] low,
    input  logic [DATA_W-1:0] high,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] iot_out
);

    localparam int BEATS = DATA_W / IN_W;
    localparam int LG    = $clog2(GRP);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = DATA_W + LG;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [LG-1:0] LAST_SAMP = LG'(GRP - 1);

    typedef enum logic {RECV = 1'b0, EVAL = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       beat_cnt;
    logic [LG-1:0]       samp_cnt;
    logic [DATA_W-1:0]   samp_p0;
    logic [2:0]          fn;
    logic [DATA_W-1:0]   mx, mn, peak;
    logic [SW-1:0]       sum;
    logic                peak_valid;
    logic [DATA_W-1:0]   mx_n, mn_n, res;
    logic [SW-1:0]       sum_n;
    logic                emit, upd_peak;
    logic                accept, first_samp, last_samp;

    function automatic logic lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef IOTDF_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] a);
`ifdef IOTDF_SIGNED_EN
        return {{LG{a[DATA_W-1]}}, a};
`else
        return {{LG{1'b0}}, a};
`endif
    endfunction

    // Average truncates; in signed mode the arithmetic shift rounds toward -inf.
    function automatic logic [DATA_W-1:0] avg(input logic [SW-1:0] s);
        logic [SW-1:0] q;
`ifdef IOTDF_SIGNED_EN
        logic signed [SW-1:0] t;
        t = s;
        q = t >>> LG;
`else
        q = s >> LG;
`endif
        return q[DATA_W-1:0];
    endfunction

    assign busy       = (state == EVAL);
    assign accept     = in_en && (state == RECV);
    assign first_samp = (samp_cnt == '0);
    assign last_samp  = (samp_cnt == LAST_SAMP);

    // Stage p0 -> p1: evaluate the assembled sample during the single EVAL cycle.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        upd_peak  = 1'b0;
        res       = samp_p0;
        mx_n      = mx;
        mn_n      = mn;
        sum_n     = sum;
        if (state == RECV) begin
            if (accept && (beat_cnt == LAST_BEAT))
                state_nxt = EVAL;
        end else begin
            state_nxt = RECV;
            if (first_samp) begin
                mx_n  = samp_p0;
                mn_n  = samp_p0;
                sum_n = ext(samp_p0);
            end else begin
                mx_n  = lt(mx, samp_p0) ? samp_p0 : mx;
                mn_n  = lt(samp_p0, mn) ? samp_p0 : mn;
                sum_n = sum + ext(samp_p0);
            end
            case (fn)
                3'd0: emit = 1'b1;
                3'd1: begin emit = last_samp; res = mx_n; end
                3'd2: begin emit = last_samp; res = mn_n; end
                3'd3: begin emit = last_samp; res = avg(sum_n); end
                3'd4: emit = lt(low, samp_p0) && lt(samp_p0, high);
                3'd5: emit = lt(samp_p0, low) || lt(high, samp_p0);
                3'd6: begin
                    res = mx_n;
                    if (last_samp && (!peak_valid || lt(peak, mx_n))) begin
                        emit     = 1'b1;
                        upd_peak = 1'b1;
                    end
                end
                3'd7: begin
                    res = mn_n;
                    if (last_samp && (!peak_valid || lt(mn_n, peak))) begin
                        emit     = 1'b1;
                        upd_peak = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RECV;
            beat_cnt   <= '0;
            samp_cnt   <= '0;
            samp_p0    <= '0;
            fn         <= '0;
            mx         <= '0;
            mn         <= '0;
            sum        <= '0;
            peak       <= '0;
            peak_valid <= 1'b0;
            valid      <= 1'b0;
            iot_out    <= '0;
        end else begin
            state <= state_nxt;
            valid <= 1'b0;
            if (accept) begin
                samp_p0[int'(beat_cnt)*IN_W +: IN_W] <= iot_in;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
                if (first_samp && (beat_cnt == '0)) begin
                    fn <= fn_sel;
                    if (fn_sel != fn)
                        peak_valid <= 1'b0;
                end
            end
            // Stage p1: register group accumulators and the output strobe.
            if (state == EVAL) begin
                mx       <= mx_n;
                mn       <= mn_n;
                sum      <= sum_n;
                samp_cnt <= samp_cnt + LG'(1);
                if (emit) begin
                    valid   <= 1'b1;
                    iot_out <= res;
                end
                if (upd_peak) begin
                    peak       <= res;
                    peak_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iotdf_param.sv
// Bench for iotdf_param: directed scenarios plus randomized groups against a group-level reference model.
module tb_iotdf_param;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_en = 1'b0;
    logic [7:0]   iot_in = '0;
    logic [2:0]   fn_sel = '0;
    logic [127:0] lo = '0;
    logic [127:0] hi = '0;
    logic         busy, valid;
    logic [127:0] iot_out;

    always #5 clk = ~clk;

    iotdf_param #(.DATA_W(128), .IN_W(8), .GRP(8)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
        .low(lo), .high(hi), .busy(busy), .valid(valid), .iot_out(iot_out)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [127:0] outq[$];
    logic [127:0] expq[$];
    int bq[$];
    int vq[$];
    logic [127:0] gs[8];
    int tv[8];

    logic [2:0]   m_fn = '0;
    logic         m_pv = 1'b0;
    logic [127:0] m_peak = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) bq.push_back(cyc);
        if (valid === 1'b1) begin
            outq.push_back(iot_out);
            vq.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic [2:0] fs);
        bit b;
        bit ok;
        ok = 1'b0;
        in_en = 1'b1;
        iot_in = d;
        fn_sel = fs;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            b = busy;
            @(posedge clk);
            #1;
            if (!b) begin
                ok = 1'b1;
                break;
            end
        end
        assert (ok) else begin
            n_err++;
            $error("FAIL beat_accept: got timeout expected accept");
        end
    endtask

    task automatic drive_sample(input logic [127:0] s, input logic [2:0] f, input bit grp_first);
        for (int k = 0; k < 16; k++)
            send_beat(s[k*8 +: 8], (grp_first && k == 0) ? f : 3'($urandom()));
    endtask

    task automatic drive_group(input logic [2:0] f);
        for (int j = 0; j < 8; j++)
            drive_sample(gs[j], f, j == 0);
    endtask

    task automatic drain();
        in_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic load_tv();
        for (int j = 0; j < 8; j++) gs[j] = 128'(tv[j]);
    endtask

    task automatic cmp_out(input string tag);
        check({tag, "_count"}, 128'(outq.size()), 128'(expq.size()));
        for (int i = 0; i < outq.size() && i < expq.size(); i++)
            check($sformatf("%s[%0d]", tag, i), outq[i], expq[i]);
        outq.delete();
        expq.delete();
    endtask

    function automatic bit m_lt(input logic [127:0] a, input logic [127:0] b);
`ifdef IOTDF_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    // Reference: whole-group results from the function rules, applied to gs[].
    task automatic model_group(input logic [2:0] f);
        logic [127:0] mx, mn, av;
        logic signed [130:0] sm, sh;
        if (f != m_fn) m_pv = 1'b0;
        m_fn = f;
        mx = gs[0];
        mn = gs[0];
        sm = '0;
        for (int j = 0; j < 8; j++) begin
            if (m_lt(mx, gs[j])) mx = gs[j];
            if (m_lt(gs[j], mn)) mn = gs[j];
`ifdef IOTDF_SIGNED_EN
            sm = sm + {{3{gs[j][127]}}, gs[j]};
`else
            sm = sm + {3'b000, gs[j]};
`endif
        end
`ifdef IOTDF_SIGNED_EN
        sh = sm >>> 3;
`else
        sh = sm >> 3;
`endif
        av = sh[127:0];
        case (f)
            3'd0: for (int j = 0; j < 8; j++) expq.push_back(gs[j]);
            3'd1: expq.push_back(mx);
            3'd2: expq.push_back(mn);
            3'd3: expq.push_back(av);
            3'd4: for (int j = 0; j < 8; j++) if (m_lt(lo, gs[j]) && m_lt(gs[j], hi)) expq.push_back(gs[j]);
            3'd5: for (int j = 0; j < 8; j++) if (m_lt(gs[j], lo) || m_lt(hi, gs[j])) expq.push_back(gs[j]);
            3'd6: if (!m_pv || m_lt(m_peak, mx)) begin expq.push_back(mx); m_peak = mx; m_pv = 1'b1; end
            3'd7: if (!m_pv || m_lt(mn, m_peak)) begin expq.push_back(mn); m_peak = mn; m_pv = 1'b1; end
        endcase
    endtask

    initial begin
        logic [2:0] f;
        // Power-on reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(valid), 128'(0));
        check("rst_iot_out", iot_out, '0);
        rst = 1'b1;

        // Reset mid-sample discards the partial beats
        for (int k = 0; k < 5; k++) send_beat(8'hA0 + 8'(k), 3'd0);
        in_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_valid", 128'(valid), 128'(0));
        check("midrst_iot_out", iot_out, '0);
        rst = 1'b1;
        outq.delete();
        for (int j = 0; j < 8; j++) begin
            gs[j] = {$urandom(), $urandom(), $urandom(), $urandom()};
            expq.push_back(gs[j]);
        end
        drive_group(3'd0);
        drain();
        cmp_out("t1_pass");

        // Group max with in_en held high: busy cadence and valid latency
        tv = '{3, 1, 8, 2, 7, 5, 6, 4};
        load_tv();
        bq.delete();
        vq.delete();
        expq.push_back(128'd8);
        drive_group(3'd1);
        drain();
        check("t2_busy_pulses", 128'(bq.size()), 128'(8));
        for (int i = 1; i < bq.size(); i++)
            check($sformatf("t2_busy_gap%0d", i), 128'(bq[i] - bq[i-1]), 128'(17));
        check("t2_valid_pulses", 128'(vq.size()), 128'(1));
        if (vq.size() > 0 && bq.size() > 0)
            check("t2_valid_latency", 128'(vq[0]), 128'(bq[bq.size()-1] + 1));
        cmp_out("t2_max");

        // Group average, including an all-ones group
        tv = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_tv();
        expq.push_back(128'd4);
        drive_group(3'd3);
        for (int j = 0; j < 8; j++) gs[j] = '1;
        expq.push_back('1);
        drive_group(3'd3);
        drain();
        cmp_out("t3_avg");
        check("t3_hold_out", iot_out, '1);
        check("t3_hold_valid", 128'(valid), 128'(0));

        // Extract / exclude windows
        lo = 128'd5;
        hi = 128'd10;
        tv = '{3, 5, 7, 10, 12, 9, 0, 6};
        load_tv();
        expq.push_back(128'd7); expq.push_back(128'd9); expq.push_back(128'd6);
        drive_group(3'd4);
        drain();
        cmp_out("t4_extract");
        expq.push_back(128'd3); expq.push_back(128'd12); expq.push_back(128'd0);
        drive_group(3'd5);
        drain();
        cmp_out("t4_exclude");

        // Peak max, then peak min after the function switch clears the peak
        for (int j = 0; j < 8; j++) gs[j] = 128'(8'h50 - 3 * j);
        drive_group(3'd6);
        for (int j = 0; j < 8; j++) gs[j] = 128'(8'h19 + 5 * j);
        drive_group(3'd6);
        for (int j = 0; j < 8; j++) gs[j] = 128'(8'h60 - 7 * j);
        drive_group(3'd6);
        for (int j = 0; j < 8; j++) gs[j] = 128'(8'h77 - j);
        drive_group(3'd7);
        for (int j = 0; j < 8; j++) gs[j] = 128'(8'h80 + j);
        drive_group(3'd7);
        for (int j = 0; j < 8; j++) gs[j] = 128'(8'h6C - j);
        drive_group(3'd7);
        drain();
        expq.push_back(128'h50); expq.push_back(128'h60);
        expq.push_back(128'h70); expq.push_back(128'h65);
        cmp_out("t5_peak");

        // Group min across the sign boundary
        gs[0] = '1;
        gs[1] = 128'd1;
        for (int j = 2; j < 8; j++) gs[j] = 128'(j);
`ifdef IOTDF_SIGNED_EN
        expq.push_back('1);
`else
        expq.push_back(128'd1);
`endif
        drive_group(3'd2);
        drain();
        cmp_out("t6_min");

        // Randomized groups against the reference model
        rst = 1'b0;
        in_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_fn = '0;
        m_pv = 1'b0;
        m_peak = '0;
        outq.delete();
        f = 3'd0;
        for (int g = 0; g < 16; g++) begin
            if ($urandom_range(0, 2) != 0) f = 3'($urandom_range(0, 7));
            lo = 128'($urandom_range(0, 40));
            hi = 128'($urandom_range(0, 40));
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 1) == 1)
                    gs[j] = 128'($urandom_range(0, 40));
                else
                    gs[j] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            model_group(f);
            drive_group(f);
            drain();
            cmp_out($sformatf("rnd_g%0d_f%0d", g, f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
